// File: rtl/apb_master_if.sv
// Command, response and APB bus signals of the APB master.
// The master modport is the DUT side; the slave modport is the requester/APB-slave side.
interface apb_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DATA_STRB  = DATA_WIDTH / 8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic                  cmd_write;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic [DATA_STRB-1:0]  cmd_strb;
    logic [2:0]            cmd_prot;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;

    logic [ADDR_WIDTH-1:0] paddr;
    logic [2:0]            prot;
    logic                  pwrite;
    logic                  psel;
    logic                  penable;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_STRB-1:0]  pstrb;
    logic                  pready;
    logic                  slverr;
    logic [DATA_WIDTH-1:0] prdata;

    modport master (
        input  cmd_valid, cmd_addr, cmd_write, cmd_wdata, cmd_strb, cmd_prot,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  rsp_ready,
        output paddr, prot, pwrite, psel, penable, pwdata, pstrb,
        input  pready, slverr, prdata
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_write, cmd_wdata, cmd_strb, cmd_prot,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output rsp_ready,
        input  paddr, prot, pwrite, psel, penable, pwdata, pstrb,
        output pready, slverr, prdata
    );
endinterface

// File: rtl/apb_master.sv
// Single-outstanding APB master: accepts one command, runs SETUP/ACCESS with a
// bounded wait, and presents a held response until it is consumed.
module apb_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DATA_STRB  = DATA_WIDTH / 8,
    parameter int TIMEOUT    = 16
) (
    input  logic         clk,
    input  logic         prst,
    apb_master_if.master bus
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t                state_q, state_d;
    logic [7:0]            wait_q, wait_d;
    logic                  accept, done, expire;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] wdata_d, rdata_d;
    logic [DATA_STRB-1:0]  strb_d;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        accept  = 1'b0;
        done    = 1'b0;
        expire  = 1'b0;
        addr_d  = bus.cmd_addr;
        wdata_d = bus.cmd_write ? bus.cmd_wdata : '0;
        strb_d  = bus.cmd_write ? bus.cmd_strb : '0;
        rdata_d = (bus.pready && !bus.pwrite) ? bus.prdata : '0;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid && bus.cmd_ready) begin
                    accept  = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                wait_d  = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                // pready wins over an expiring counter in the same cycle
                if (bus.pready) begin
                    done    = 1'b1;
                    state_d = RESP;
                end else if (wait_q == WAIT_LAST) begin
                    expire  = 1'b1;
                    state_d = RESP;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge prst) begin
        if (prst) begin
            state_q <= IDLE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge prst) begin
        if (prst) begin
            bus.cmd_ready   <= 1'b0;
            bus.psel        <= 1'b0;
            bus.penable     <= 1'b0;
            bus.paddr       <= '0;
            bus.prot        <= '0;
            bus.pwrite      <= 1'b0;
            bus.pwdata      <= '0;
            bus.pstrb       <= '0;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_rdata   <= '0;
            bus.rsp_err     <= 1'b0;
            bus.rsp_timeout <= 1'b0;
        end else begin
            bus.cmd_ready <= (state_d == IDLE);
            bus.psel      <= (state_d == SETUP) || (state_d == ACCESS);
            bus.penable   <= (state_d == ACCESS);
            if (accept) begin
                bus.paddr  <= addr_d;
                bus.prot   <= bus.cmd_prot;
                bus.pwrite <= bus.cmd_write;
                bus.pwdata <= wdata_d;
                bus.pstrb  <= strb_d;
            end
            if (done || expire) begin
                bus.rsp_valid   <= 1'b1;
                bus.rsp_rdata   <= rdata_d;
                bus.rsp_err     <= expire || bus.slverr;
                bus.rsp_timeout <= expire;
            end else if (state_q == RESP && bus.rsp_ready) begin
                bus.rsp_valid <= 1'b0;
            end
        end
    end
endmodule
